icache: RTL and testbench

Direct-mapped instruction cache between the instruction-fetch unit and the memory controller. It serves fetch requests from a local tag/data array. On a miss it raises a fetch request to the memory controller, waits for the assembled 32-bit instruction, fills the line, and returns the instruction to fetch. It holds one outstanding request at a time and aborts cleanly on rollback.

---
 rtl/icache_pkg.sv | 13 +
 rtl/icache_array.sv | 57 +++++
 rtl/icache.sv | 125 ++++++++++++
 tb/tb_icache.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared constants for the instruction cache: boolean levels, FSM encodings
// and the default geometry.
package icache_pkg;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   localparam int DEFAULT_INDEX_BITS = 8;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_MISS = 1'b1;

endpackage

// File: rtl/icache_array.sv
// Direct-mapped line storage: valid/tag/data per one-word line, synchronous
// write, asynchronous read, valid bits cleared synchronously on rst.
module icache_array
   import icache_pkg::*;
#(
   parameter int INDEX_BITS = DEFAULT_INDEX_BITS,
   parameter int TAG_BITS   = 30 - INDEX_BITS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [INDEX_BITS-1:0] wr_index,
   input  logic [TAG_BITS-1:0]   wr_tag,
   input  logic [31:0]           wr_data,
   input  logic [INDEX_BITS-1:0] rd_index,
   output logic                  rd_valid,
   output logic [TAG_BITS-1:0]   rd_tag,
   output logic [31:0]           rd_data
);

   localparam int LINES = 1 << INDEX_BITS;

   logic [LINES-1:0]    valid_q;
   logic [LINES-1:0]    valid_d;
   logic [TAG_BITS-1:0] tag_mem  [LINES];
   logic [31:0]         data_mem [LINES];

   // Next valid vector: reset wipes every line, a fill marks one line valid.
   always_comb begin
      valid_d = valid_q;
      if (rst) begin
         valid_d = '0;
      end else if (wr_en) begin
         valid_d[wr_index] = TRUE;
      end else begin
         valid_d = valid_q;
      end
   end

   // Valid bits register.
   always_ff @(posedge clk) begin
      valid_q <= valid_d;
   end

   // Tag and data storage; contents are don't-care until the valid bit is set.
   always_ff @(posedge clk) begin
      if (wr_en && !rst) begin
         tag_mem[wr_index]  <= wr_tag;
         data_mem[wr_index] <= wr_data;
      end
   end

   assign rd_valid = valid_q[rd_index];
   assign rd_tag   = tag_mem[rd_index];
   assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache: serves fetch hits locally, forwards misses
// to the memory controller one at a time, and aborts on rollback.
module icache
   import icache_pkg::*;
#(
   parameter int INDEX_BITS = DEFAULT_INDEX_BITS,
   parameter int TAG_BITS   = 30 - INDEX_BITS
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        rollback,
   input  logic        fetch_valid,
   input  logic [31:0] fetch_pc,
   output logic        hit_valid,
   output logic [31:0] ins,
   output logic [31:0] mem_pc,
   output logic        mem_miss,
   input  logic        mem_finish,
   input  logic [31:0] mem_ins
);

   logic [0:0]  state_q,     state_d;
   logic        hit_valid_q, hit_valid_d;
   logic [31:0] ins_q,       ins_d;
   logic [31:0] mem_pc_q,    mem_pc_d;

   logic [INDEX_BITS-1:0] fetch_index;
   logic [TAG_BITS-1:0]   fetch_tag;
   logic                  rd_valid;
   logic [TAG_BITS-1:0]   rd_tag;
   logic [31:0]           rd_data;
   logic                  lookup_hit;
   logic                  wr_en;

   assign fetch_index = fetch_pc[INDEX_BITS+1:2];
   assign fetch_tag   = fetch_pc[31:INDEX_BITS+2];
   assign lookup_hit  = rd_valid && (rd_tag == fetch_tag);

   icache_array #(
      .INDEX_BITS (INDEX_BITS),
      .TAG_BITS   (TAG_BITS)
   ) u_array (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_index (mem_pc_q[INDEX_BITS+1:2]),
      .wr_tag   (mem_pc_q[31:INDEX_BITS+2]),
      .wr_data  (mem_ins),
      .rd_index (fetch_index),
      .rd_valid (rd_valid),
      .rd_tag   (rd_tag),
      .rd_data  (rd_data)
   );

   // FSM and output-register next state; rdy low holds everything.
   always_comb begin
      state_d     = state_q;
      hit_valid_d = hit_valid_q;
      ins_d       = ins_q;
      mem_pc_d    = mem_pc_q;
      wr_en       = FALSE;
      if (rst) begin
         state_d     = ST_IDLE;
         hit_valid_d = FALSE;
         ins_d       = 32'h0000_0000;
         mem_pc_d    = 32'h0000_0000;
      end else if (rdy) begin
         if (rollback) begin
            // A mem_finish landing here belongs to the squashed path.
            state_d     = ST_IDLE;
            hit_valid_d = FALSE;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  hit_valid_d = FALSE;
                  if (fetch_valid && !hit_valid_q) begin
                     if (lookup_hit) begin
                        hit_valid_d = TRUE;
                        ins_d       = rd_data;
                     end else begin
                        mem_pc_d = fetch_pc;
                        state_d  = ST_MISS;
                     end
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
               ST_MISS: begin
                  hit_valid_d = FALSE;
                  if (mem_finish) begin
                     wr_en       = TRUE;
                     hit_valid_d = TRUE;
                     ins_d       = mem_ins;
                     state_d     = ST_IDLE;
                  end else begin
                     state_d = ST_MISS;
                  end
               end
               default: begin
                  state_d     = ST_IDLE;
                  hit_valid_d = FALSE;
               end
            endcase
         end
      end else begin
         state_d = state_q;
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      state_q     <= state_d;
      hit_valid_q <= hit_valid_d;
      ins_q       <= ins_d;
      mem_pc_q    <= mem_pc_d;
   end

   // Dropped in the finish cycle so the controller never re-launches the fetch.
   assign mem_miss  = (state_q == ST_MISS) && !mem_finish;
   assign hit_valid = hit_valid_q;
   assign ins       = ins_q;
   assign mem_pc    = mem_pc_q;

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: per-cycle directed vector table plus a
// hand-written reset sequence and a memory-controller fetch counter.
module tb_icache;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rdy = 1'b1;
   logic        rollback = 1'b0;
   logic        fetch_valid = 1'b0;
   logic [31:0] fetch_pc = 32'h0;
   logic        hit_valid;
   logic [31:0] ins;
   logic [31:0] mem_pc;
   logic        mem_miss;
   logic        mem_finish = 1'b0;
   logic [31:0] mem_ins = 32'h0;

   int errors = 0;
   int checks = 0;
   int mc_fetches = 0;
   logic mc_busy = 1'b0;

   typedef struct {
      logic        fv;
      logic [31:0] pc;
      logic        mf;
      logic [31:0] mi;
      logic        rb;
      logic        rdy;
      logic        e_miss;
      logic        e_hit;
      logic [31:0] e_ins;
      logic [31:0] e_mpc;
   } vec_t;

   vec_t vecs[$];

   icache dut (
      .clk         (clk),
      .rst         (rst),
      .rdy         (rdy),
      .rollback    (rollback),
      .fetch_valid (fetch_valid),
      .fetch_pc    (fetch_pc),
      .hit_valid   (hit_valid),
      .ins         (ins),
      .mem_pc      (mem_pc),
      .mem_miss    (mem_miss),
      .mem_finish  (mem_finish),
      .mem_ins     (mem_ins)
   );

   always #5 clk = ~clk;

   // Memory-controller observer: counts fetches it would launch.
   always @(posedge clk) begin
      if (!rst) begin
         if (mem_miss && !mc_busy) mc_fetches <= mc_fetches + 1;
         if (mem_finish || rollback) mc_busy <= 1'b0;
         else if (mem_miss) mc_busy <= 1'b1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic void add(input logic fv, input logic [31:0] pc, input logic mf,
                               input logic [31:0] mi, input logic rb, input logic rd,
                               input logic em, input logic eh, input logic [31:0] ei,
                               input logic [31:0] ep);
      vec_t v;
      v.fv = fv; v.pc = pc; v.mf = mf; v.mi = mi; v.rb = rb; v.rdy = rd;
      v.e_miss = em; v.e_hit = eh; v.e_ins = ei; v.e_mpc = ep;
      vecs.push_back(v);
   endfunction

   initial begin
      // fv, pc, mf, mi, rb, rdy | mem_miss(before edge), hit_valid, ins, mem_pc (after edge)
      add(1, 32'h0,   0, 32'h0,         0, 1,  0, 0, 32'h0,         32'h0);
      add(1, 32'h0,   0, 32'h0,         0, 1,  1, 0, 32'h0,         32'h0);
      add(1, 32'h0,   1, 32'h0000_0093, 0, 1,  0, 1, 32'h0000_0093, 32'h0);
      add(1, 32'h0,   0, 32'h0,         0, 1,  0, 0, 32'h0000_0093, 32'h0);
      add(1, 32'h0,   0, 32'h0,         0, 1,  0, 1, 32'h0000_0093, 32'h0);
      add(0, 32'h0,   0, 32'h0,         0, 1,  0, 0, 32'h0000_0093, 32'h0);
      // conflict on index 0
      add(1, 32'h400, 0, 32'h0,         0, 1,  0, 0, 32'h0000_0093, 32'h400);
      add(1, 32'h400, 0, 32'h0,         0, 1,  1, 0, 32'h0000_0093, 32'h400);
      add(1, 32'h400, 1, 32'hAAAA_0001, 0, 1,  0, 1, 32'hAAAA_0001, 32'h400);
      add(1, 32'h0,   0, 32'h0,         0, 1,  0, 0, 32'hAAAA_0001, 32'h400);
      add(1, 32'h0,   0, 32'h0,         0, 1,  0, 0, 32'hAAAA_0001, 32'h0);
      add(1, 32'h0,   0, 32'h0,         0, 1,  1, 0, 32'hAAAA_0001, 32'h0);
      add(1, 32'h0,   1, 32'h0000_0093, 0, 1,  0, 1, 32'h0000_0093, 32'h0);
      add(0, 32'h0,   0, 32'h0,         0, 1,  0, 0, 32'h0000_0093, 32'h0);
      // rollback together with mem_finish discards the fill
      add(1, 32'h10,  0, 32'h0,         0, 1,  0, 0, 32'h0000_0093, 32'h10);
      add(1, 32'h10,  0, 32'h0,         0, 1,  1, 0, 32'h0000_0093, 32'h10);
      add(1, 32'h10,  1, 32'h1234_5678, 1, 1,  0, 0, 32'h0000_0093, 32'h10);
      add(1, 32'h10,  0, 32'h0,         0, 1,  0, 0, 32'h0000_0093, 32'h10);
      add(1, 32'h10,  0, 32'h0,         0, 1,  1, 0, 32'h0000_0093, 32'h10);
      add(1, 32'h10,  1, 32'h1234_5678, 0, 1,  0, 1, 32'h1234_5678, 32'h10);
      add(0, 32'h0,   0, 32'h0,         0, 1,  0, 0, 32'h1234_5678, 32'h10);
      // rollback keeps array contents
      add(1, 32'h20,  0, 32'h0,         0, 1,  0, 0, 32'h1234_5678, 32'h20);
      add(1, 32'h20,  0, 32'h0,         0, 1,  1, 0, 32'h1234_5678, 32'h20);
      add(1, 32'h20,  1, 32'h0050_0513, 0, 1,  0, 1, 32'h0050_0513, 32'h20);
      add(0, 32'h0,   0, 32'h0,         1, 1,  0, 0, 32'h0050_0513, 32'h20);
      add(1, 32'h20,  0, 32'h0,         0, 1,  0, 1, 32'h0050_0513, 32'h20);
      add(0, 32'h0,   0, 32'h0,         0, 1,  0, 0, 32'h0050_0513, 32'h20);
      // rdy low freezes a pending miss
      add(1, 32'h30,  0, 32'h0,         0, 1,  0, 0, 32'h0050_0513, 32'h30);
      for (int i = 0; i < 5; i++)
         add(1, 32'h44, 0, 32'h0,       0, 0,  1, 0, 32'h0050_0513, 32'h30);
      add(1, 32'h30,  1, 32'hDEAD_BEEF, 0, 1,  0, 1, 32'hDEAD_BEEF, 32'h30);
      add(0, 32'h0,   0, 32'h0,         0, 1,  0, 0, 32'hDEAD_BEEF, 32'h30);
      // rollback during a miss, then a stray mem_finish in IDLE
      add(1, 32'h40,  0, 32'h0,         0, 1,  0, 0, 32'hDEAD_BEEF, 32'h40);
      add(0, 32'h0,   0, 32'h0,         1, 1,  1, 0, 32'hDEAD_BEEF, 32'h40);
      add(0, 32'h0,   0, 32'h0,         0, 1,  0, 0, 32'hDEAD_BEEF, 32'h40);
      add(0, 32'h0,   1, 32'h1111_1111, 0, 1,  0, 0, 32'hDEAD_BEEF, 32'h40);
      add(1, 32'h40,  0, 32'h0,         0, 1,  0, 0, 32'hDEAD_BEEF, 32'h40);
      add(1, 32'h40,  0, 32'h0,         0, 1,  1, 0, 32'hDEAD_BEEF, 32'h40);
      add(1, 32'h40,  1, 32'h2222_2222, 0, 1,  0, 1, 32'h2222_2222, 32'h40);
      add(0, 32'h0,   0, 32'h0,         0, 1,  0, 0, 32'h2222_2222, 32'h40);

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("reset hit_valid", {31'h0, hit_valid}, 32'h0);
      chk("reset ins", ins, 32'h0);
      chk("reset mem_pc", mem_pc, 32'h0);
      chk("reset mem_miss", {31'h0, mem_miss}, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         fetch_valid = vecs[i].fv;
         fetch_pc    = vecs[i].pc;
         mem_finish  = vecs[i].mf;
         mem_ins     = vecs[i].mi;
         rollback    = vecs[i].rb;
         rdy         = vecs[i].rdy;
         #1;
         chk($sformatf("v%0d mem_miss", i), {31'h0, mem_miss}, {31'h0, vecs[i].e_miss});
         @(posedge clk);
         #1;
         chk($sformatf("v%0d hit_valid", i), {31'h0, hit_valid}, {31'h0, vecs[i].e_hit});
         chk($sformatf("v%0d ins", i), ins, vecs[i].e_ins);
         chk($sformatf("v%0d mem_pc", i), mem_pc, vecs[i].e_mpc);
      end

      // mid-run reset clears outputs and invalidates the filled line at 0x20
      @(negedge clk);
      fetch_valid = 1'b0; mem_finish = 1'b0; rollback = 1'b0; rdy = 1'b1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst2 hit_valid", {31'h0, hit_valid}, 32'h0);
      chk("rst2 ins", ins, 32'h0);
      chk("rst2 mem_pc", mem_pc, 32'h0);
      @(negedge clk);
      rst = 1'b0; fetch_valid = 1'b1; fetch_pc = 32'h20;
      @(posedge clk);
      #1;
      chk("rst2 refetch misses", {31'h0, mem_miss}, 32'h1);
      chk("rst2 refetch mem_pc", mem_pc, 32'h20);
      @(negedge clk);
      @(negedge clk);
      mem_finish = 1'b1; mem_ins = 32'h0000_0005;
      #1;
      chk("rst2 miss drop", {31'h0, mem_miss}, 32'h0);
      @(posedge clk);
      #1;
      chk("rst2 fill hit_valid", {31'h0, hit_valid}, 32'h1);
      chk("rst2 fill ins", ins, 32'h0000_0005);
      @(negedge clk);
      fetch_valid = 1'b0; mem_finish = 1'b0;
      @(negedge clk);
      chk("memctl fetch count", mc_fetches, 32'd10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
